// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter between the in-order WB stage and a 1-entry
// mul/div result buffer, with starvation limit and WAW ordering.
module wb_port_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pipe_wen,
    input  logic [ADDR_W-1:0] pipe_waddr,
    input  logic [DATA_W-1:0] pipe_wdata,
    output logic              pipe_stall,
    input  logic              md_valid,
    input  logic [ADDR_W-1:0] md_waddr,
    input  logic [DATA_W-1:0] md_wdata,
    output logic              md_ready,
    output logic              md_pending,
    output logic [ADDR_W-1:0] pending_waddr,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    typedef enum logic {EMPTY = 1'b0, HELD = 1'b1} buf_state_t;

    buf_state_t        state, state_nxt;
    logic [ADDR_W-1:0] buf_waddr;
    logic [DATA_W-1:0] buf_wdata;
    logic [CNT_W-1:0]  starve_cnt, starve_nxt;
    logic              buf_valid, pipe_req, capture, grant_buf, grant_pipe;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == STARVE_LIM) ? v : v + 1'b1;
    endfunction

    assign buf_valid     = (state == HELD);
    assign pipe_req      = pipe_wen && (pipe_waddr != '0);
    assign capture       = !buf_valid && md_valid && (md_waddr != '0);
    assign md_ready      = !buf_valid;
    assign md_pending    = buf_valid;
    assign pending_waddr = buf_waddr;

    // A same-address WB write must wait so the older mul/div result lands first.
    assign grant_buf  = buf_valid && (!pipe_req || (starve_cnt == STARVE_LIM)
                                      || (pipe_waddr == buf_waddr));
    assign grant_pipe = pipe_req && !grant_buf;
    assign pipe_stall = pipe_req && grant_buf;

    always_comb begin
        state_nxt  = state;
        starve_nxt = starve_cnt;
        case (state)
            EMPTY: begin
                starve_nxt = '0;
                if (capture) state_nxt = HELD;
            end
            HELD: begin
                if (grant_buf) begin
                    state_nxt  = EMPTY;
                    starve_nxt = '0;
                end else if (grant_pipe) begin
                    starve_nxt = sat_inc(starve_cnt);
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            starve_cnt <= '0;
            buf_waddr  <= '0;
            buf_wdata  <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            if (capture) begin
                buf_waddr <= md_waddr;
                buf_wdata <= md_wdata;
            end
        end
    end

    // Registered write port: the winner of cycle N reaches the regfile at edge N+1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= grant_buf | grant_pipe;
            if (grant_buf) begin
                rf_waddr <= buf_waddr;
                rf_wdata <= buf_wdata;
            end else if (grant_pipe) begin
                rf_waddr <= pipe_waddr;
                rf_wdata <= pipe_wdata;
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter (default parameters).
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pipe_wen;
    logic [4:0]  pipe_waddr;
    logic [31:0] pipe_wdata;
    logic        pipe_stall;
    logic        md_valid;
    logic [4:0]  md_waddr;
    logic [31:0] md_wdata;
    logic        md_ready, md_pending;
    logic [4:0]  pending_waddr;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int checks = 0;
    int failures = 0;

    wb_port_arbiter #(.DATA_W(32), .ADDR_W(5), .STARVE_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .pipe_wen(pipe_wen), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
        .pipe_stall(pipe_stall),
        .md_valid(md_valid), .md_waddr(md_waddr), .md_wdata(md_wdata),
        .md_ready(md_ready), .md_pending(md_pending), .pending_waddr(pending_waddr),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    always #5 clk = ~clk;

    task automatic drive_idle();
        pipe_wen = 1'b0; pipe_waddr = '0; pipe_wdata = '0;
        md_valid = 1'b0; md_waddr = '0;   md_wdata = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        #1;
        checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL reset_rf_we got=%b exp=0", rf_we); end
        checks++; if (rf_waddr !== 5'd0) begin failures++; $display("FAIL reset_rf_waddr got=%0d exp=0", rf_waddr); end
        checks++; if (rf_wdata !== 32'd0) begin failures++; $display("FAIL reset_rf_wdata got=%h exp=0", rf_wdata); end
        checks++; if (md_ready !== 1'b1) begin failures++; $display("FAIL reset_md_ready got=%b exp=1", md_ready); end
        checks++; if (md_pending !== 1'b0) begin failures++; $display("FAIL reset_md_pending got=%b exp=0", md_pending); end
        checks++; if (pending_waddr !== 5'd0) begin failures++; $display("FAIL reset_pending_waddr got=%0d exp=0", pending_waddr); end
        checks++; if (pipe_stall !== 1'b0) begin failures++; $display("FAIL reset_pipe_stall got=%b exp=0", pipe_stall); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_pipe_only();
        @(negedge clk);
        pipe_wen = 1'b1; pipe_waddr = 5'd5; pipe_wdata = 32'h1234;
        #1;
        checks++; if (pipe_stall !== 1'b0) begin failures++; $display("FAIL t1_stall got=%b exp=0", pipe_stall); end
        @(posedge clk); #1;
        checks++; if (rf_we !== 1'b1) begin failures++; $display("FAIL t1_rf_we got=%b exp=1", rf_we); end
        checks++; if (rf_waddr !== 5'd5) begin failures++; $display("FAIL t1_rf_waddr got=%0d exp=5", rf_waddr); end
        checks++; if (rf_wdata !== 32'h1234) begin failures++; $display("FAIL t1_rf_wdata got=%h exp=1234", rf_wdata); end
        @(negedge clk); drive_idle();
        @(posedge clk); #1;
        checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL t1_idle_we got=%b exp=0", rf_we); end
        checks++; if (rf_waddr !== 5'd5 || rf_wdata !== 32'h1234) begin failures++; $display("FAIL t1_hold got=%0d/%h exp=5/1234", rf_waddr, rf_wdata); end
    endtask

    task automatic test_md_alone();
        @(negedge clk);
        md_valid = 1'b1; md_waddr = 5'd7; md_wdata = 32'hDEADBEEF;
        #1;
        checks++; if (md_ready !== 1'b1) begin failures++; $display("FAIL t2_ready_pre got=%b exp=1", md_ready); end
        @(posedge clk); #1;
        checks++; if (md_ready !== 1'b0 || md_pending !== 1'b1) begin failures++; $display("FAIL t2_held got=ready%b/pend%b exp=0/1", md_ready, md_pending); end
        checks++; if (pending_waddr !== 5'd7) begin failures++; $display("FAIL t2_pending_waddr got=%0d exp=7", pending_waddr); end
        checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL t2_no_early_we got=%b exp=0", rf_we); end
        @(negedge clk); drive_idle();
        @(posedge clk); #1;
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL t2_write got=%b/%0d/%h exp=1/7/deadbeef", rf_we, rf_waddr, rf_wdata); end
        checks++; if (md_ready !== 1'b1 || md_pending !== 1'b0) begin failures++; $display("FAIL t2_drained got=ready%b/pend%b exp=1/0", md_ready, md_pending); end
    endtask

    task automatic test_starvation();
        logic [4:0] req_addr [6] = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd14};
        logic       exp_stl  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [4:0] exp_addr [6] = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd3, 5'd14};
        logic [31:0] exp_data;
        @(negedge clk);
        md_valid = 1'b1; md_waddr = 5'd3; md_wdata = 32'h33;
        @(negedge clk);
        md_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            pipe_wen = 1'b1; pipe_waddr = req_addr[i]; pipe_wdata = 32'hA00 + 32'(req_addr[i]);
            exp_data = (exp_addr[i] == 5'd3) ? 32'h33 : 32'hA00 + 32'(exp_addr[i]);
            #1;
            checks++; if (pipe_stall !== exp_stl[i]) begin failures++; $display("FAIL t3_stall[%0d] got=%b exp=%b", i, pipe_stall, exp_stl[i]); end
            @(posedge clk); #1;
            checks++; if (rf_we !== 1'b1 || rf_waddr !== exp_addr[i] || rf_wdata !== exp_data) begin failures++; $display("FAIL t3_write[%0d] got=%b/%0d/%h exp=1/%0d/%h", i, rf_we, rf_waddr, rf_wdata, exp_addr[i], exp_data); end
            @(negedge clk);
        end
        checks++; if (md_pending !== 1'b0) begin failures++; $display("FAIL t3_drained got=%b exp=0", md_pending); end
        drive_idle();
    endtask

    task automatic test_waw();
        @(negedge clk);
        md_valid = 1'b1; md_waddr = 5'd9; md_wdata = 32'h99;
        @(negedge clk);
        md_valid = 1'b0;
        pipe_wen = 1'b1; pipe_waddr = 5'd9; pipe_wdata = 32'h909;
        #1;
        checks++; if (pipe_stall !== 1'b1) begin failures++; $display("FAIL t4_stall got=%b exp=1", pipe_stall); end
        @(posedge clk); #1;
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'h99) begin failures++; $display("FAIL t4_md_first got=%b/%0d/%h exp=1/9/99", rf_we, rf_waddr, rf_wdata); end
        @(negedge clk); #1;
        checks++; if (pipe_stall !== 1'b0) begin failures++; $display("FAIL t4_unstall got=%b exp=0", pipe_stall); end
        @(posedge clk); #1;
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'h909) begin failures++; $display("FAIL t4_pipe_second got=%b/%0d/%h exp=1/9/909", rf_we, rf_waddr, rf_wdata); end
        @(negedge clk); drive_idle();
    endtask

    task automatic test_r0();
        @(negedge clk);
        pipe_wen = 1'b1; pipe_waddr = 5'd0; pipe_wdata = 32'hFFFF;
        md_valid = 1'b1; md_waddr = 5'd0;   md_wdata = 32'h55;
        #1;
        checks++; if (pipe_stall !== 1'b0) begin failures++; $display("FAIL t5_stall got=%b exp=0", pipe_stall); end
        @(posedge clk); #1;
        checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL t5_rf_we got=%b exp=0", rf_we); end
        checks++; if (md_ready !== 1'b1 || md_pending !== 1'b0) begin failures++; $display("FAIL t5_md got=ready%b/pend%b exp=1/0", md_ready, md_pending); end
        @(negedge clk); drive_idle();
        @(posedge clk); #1;
        checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL t5_rf_we_after got=%b exp=0", rf_we); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        md_valid = 1'b1; md_waddr = 5'd12; md_wdata = 32'hC;
        pipe_wen = 1'b1; pipe_waddr = 5'd4; pipe_wdata = 32'h44;
        @(posedge clk); #1;
        checks++; if (rf_we !== 1'b1 || md_pending !== 1'b1) begin failures++; $display("FAIL t6_pre got=we%b/pend%b exp=1/1", rf_we, md_pending); end
        drive_idle();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin failures++; $display("FAIL t6_async_rf got=%b/%0d/%h exp=0/0/0", rf_we, rf_waddr, rf_wdata); end
        checks++; if (md_pending !== 1'b0 || md_ready !== 1'b1 || pending_waddr !== 5'd0) begin failures++; $display("FAIL t6_async_buf got=pend%b/ready%b/%0d exp=0/1/0", md_pending, md_ready, pending_waddr); end
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (rf_we !== 1'b0 || md_pending !== 1'b0) begin failures++; $display("FAIL t6_discarded got=we%b/pend%b exp=0/0", rf_we, md_pending); end
        @(negedge clk);
        pipe_wen = 1'b1; pipe_waddr = 5'd2; pipe_wdata = 32'h22;
        @(posedge clk); #1;
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd2 || rf_wdata !== 32'h22) begin failures++; $display("FAIL t6_after got=%b/%0d/%h exp=1/2/22", rf_we, rf_waddr, rf_wdata); end
        @(negedge clk); drive_idle();
    endtask

    initial begin
        test_reset();
        test_pipe_only();
        test_md_alone();
        test_starvation();
        test_waw();
        test_r0();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
